cache_mem_arbiter: RTL and testbench

Two-to-one arbiter that shares the single SRAM-like memory port between the instruction-cache and data-cache miss/uncached paths, ahead of the sram-to-AXI bridge. Data side has fixed priority; an anti-starvation counter guarantees instruction-side progress. One transaction is outstanding at a time. Ownership is held from grant until the downstream `data_ok`.

---
 rtl/cache_arb_pkg.sv | 21 ++
 rtl/cache_arb_perf.sv | 28 ++
 rtl/cache_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the instruction/data cache memory-port arbiter:
// FSM state encoding, owner constants and the forwarded request bundle.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_ADDR = 2'd1,
        ARB_WAIT_DATA = 2'd2
    } arb_state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cache_arb_perf.sv
// Grant and stall performance counters for cache_mem_arbiter; instantiated
// only when CACHE_ARB_PERF_EN is defined. All counters wrap.
module cache_arb_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant_inst,
    input  logic             grant_data,
    input  logic             stall,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (grant_inst) i_grant_cnt <= i_grant_cnt + CNT_W'(1);
            if (grant_data) d_grant_cnt <= d_grant_cnt + CNT_W'(1);
            if (stall)      stall_cnt   <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between I-cache and
// D-cache. Optional performance counters under macro CACHE_ARB_PERF_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_wr,
    input  logic [1:0]       i_size,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [1:0]       d_size,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    output logic [31:0]      i_rdata,
    output logic [31:0]      d_rdata,
    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state;
    logic                owner;
    logic [STREAK_W-1:0] streak;

    logic     any_req, idle, win_data, sel, addr_phase, addr_ok_fwd, data_ok_fwd;
    mem_req_t i_rq, d_rq, sel_rq;

    always_comb begin
        any_req  = i_req | d_req;
        idle     = (state == ARB_IDLE);
        // Data has priority until the inst side has watched STARVE_LIMIT data grants.
        win_data = d_req && !(i_req && streak == STREAK_MAX);
        sel      = idle ? (win_data ? OWNER_DATA : OWNER_INST) : owner;

        i_rq   = '{wr: i_wr, size: i_size, addr: i_addr, wdata: i_wdata};
        d_rq   = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
        sel_rq = (sel == OWNER_DATA) ? d_rq : i_rq;

        addr_phase  = (idle && any_req) || (state == ARB_WAIT_ADDR);
        // data_ok outside a live transaction is spurious and dropped.
        addr_ok_fwd = !rst && addr_phase && m_addr_ok;
        data_ok_fwd = !rst && m_data_ok &&
                      ((addr_phase && m_addr_ok) || (state == ARB_WAIT_DATA));

        m_req   = !rst && addr_phase;
        m_wr    = sel_rq.wr;
        m_size  = sel_rq.size;
        m_addr  = sel_rq.addr;
        m_wdata = sel_rq.wdata;

        i_addr_ok = addr_ok_fwd && (sel == OWNER_INST);
        d_addr_ok = addr_ok_fwd && (sel == OWNER_DATA);
        i_data_ok = data_ok_fwd && (sel == OWNER_INST);
        d_data_ok = data_ok_fwd && (sel == OWNER_DATA);
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            owner  <= OWNER_INST;
            streak <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner <= sel;
                        if (win_data && i_req) begin
                            if (streak != STREAK_MAX) streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                        if (!m_addr_ok)     state <= ARB_WAIT_ADDR;
                        else if (!m_data_ok) state <= ARB_WAIT_DATA;
                    end
                end
                ARB_WAIT_ADDR: begin
                    if (m_addr_ok) state <= m_data_ok ? ARB_IDLE : ARB_WAIT_DATA;
                end
                ARB_WAIT_DATA: begin
                    if (m_data_ok) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic grant_inst, grant_data, stall;

    assign grant_inst = idle && any_req && !win_data;
    assign grant_data = idle && win_data;
    assign stall      = (i_req && sel != OWNER_INST) || (d_req && sel != OWNER_DATA);

    cache_arb_perf #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .rst        (rst),
        .grant_inst (grant_inst),
        .grant_data (grant_data),
        .stall      (stall),
        .i_grant_cnt(i_grant_cnt),
        .d_grant_cnt(d_grant_cnt),
        .stall_cnt  (stall_cnt)
    );
`else
    assign i_grant_cnt = '0;
    assign d_grant_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: random requesters and memory,
// expectations from a transaction-level model, checked by a separate monitor.
module tb_cache_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int CW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_req, i_wr, d_req, d_wr;
    logic [1:0]    i_size, d_size;
    logic [31:0]   i_addr, i_wdata, d_addr, d_wdata;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0]   i_rdata, d_rdata;
    logic          m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]    m_size;
    logic [31:0]   m_addr, m_wdata, m_rdata;
    logic [CW-1:0] i_grant_cnt, d_grant_cnt, stall_cnt;

    cache_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .i_rdata(i_rdata), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct { bit side; bit wr; bit [1:0] size; bit [31:0] addr; bit [31:0] wdata; } gexp_t;
    typedef struct { bit side; bit [31:0] rdata; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Transaction-level model: is a transaction waiting for address or data
    // acceptance, who owns it, and how many data grants inst has sat through.
    bit pend_addr, pend_data, own;
    int waited, n_ig, n_dg, n_st;
    bit acc_i, acc_d;
    int p_ireq, p_dreq, p_aok, p_same, p_dok, p_spur;
    bit fix_rd;

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic model_clear();
        gq.delete(); dq.delete();
        pend_addr = 0; pend_data = 0; own = 0; waited = 0;
        n_ig = 0; n_dg = 0; n_st = 0; acc_i = 0; acc_d = 0;
    endtask

    task automatic step();
        bit win, grant;
        @(negedge clk);
        if (acc_i) i_req = 1'b0;
        if (acc_d) d_req = 1'b0;
        acc_i = 0; acc_d = 0;
        if (!i_req && pct(p_ireq)) begin
            i_req = 1'b1; i_wr = 1'($urandom_range(1)); i_size = 2'($urandom_range(2));
            i_addr = $urandom; i_wdata = $urandom;
        end
        if (!d_req && pct(p_dreq)) begin
            d_req = 1'b1; d_wr = 1'($urandom_range(1)); d_size = 2'($urandom_range(2));
            d_addr = $urandom; d_wdata = $urandom;
        end
        m_rdata = fix_rd ? 32'hDEAD_BEEF : $urandom;
        m_addr_ok = 1'b0; m_data_ok = 1'b0;
        if (pend_data) m_data_ok = pct(p_dok);
        else if (pend_addr || i_req || d_req) begin
            m_addr_ok = pct(p_aok);
            m_data_ok = m_addr_ok && pct(p_same);
        end else m_data_ok = pct(p_spur);

        grant = !pend_addr && !pend_data && (i_req || d_req);
        if (grant) begin
            win = d_req && !(i_req && waited == LIMIT);
            own = win;
            if (win) begin
                gq.push_back('{1'b1, d_wr, d_size, d_addr, d_wdata});
                n_dg++;
                waited = i_req ? ((waited < LIMIT) ? waited + 1 : LIMIT) : 0;
            end else begin
                gq.push_back('{1'b0, i_wr, i_size, i_addr, i_wdata});
                n_ig++;
                waited = 0;
            end
        end
        if ((grant || pend_addr || pend_data) && ((i_req && own) || (d_req && !own))) n_st++;
        if (grant || pend_addr) begin
            if (m_addr_ok) begin
                if (own) acc_d = 1; else acc_i = 1;
                pend_addr = 0;
                pend_data = !m_data_ok;
                if (m_data_ok) dq.push_back('{own, m_rdata});
            end else pend_addr = 1;
        end else if (pend_data && m_data_ok) begin
            dq.push_back('{own, m_rdata});
            pend_data = 0;
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_ARB_PERF_EN
        chk(i_grant_cnt == CW'(n_ig), {tag, "_i_grant_cnt"}, 64'(i_grant_cnt), 64'(n_ig));
        chk(d_grant_cnt == CW'(n_dg), {tag, "_d_grant_cnt"}, 64'(d_grant_cnt), 64'(n_dg));
        chk(stall_cnt == CW'(n_st), {tag, "_stall_cnt"}, 64'(stall_cnt), 64'(n_st));
`else
        chk(i_grant_cnt == '0 && d_grant_cnt == '0 && stall_cnt == '0, {tag, "_cnt_zero"},
            64'(i_grant_cnt | d_grant_cnt | stall_cnt), 64'd0);
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        p_ireq = 0; p_dreq = 0;
        if (p_aok == 0) p_aok = 50;
        if (p_dok == 0) p_dok = 50;
        while ((pend_addr || pend_data || i_req || d_req) && n < 300) begin
            step(); n++;
        end
        chk(n < 300, {tag, "_drain_timeout"}, 64'(n), 64'd300);
        step(); step();
        chk(gq.size() == 0, {tag, "_grants_left"}, 64'(gq.size()), 64'd0);
        chk(dq.size() == 0, {tag, "_data_left"}, 64'(dq.size()), 64'd0);
        check_counters(tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        // Hammer the inputs during reset: every handshake output must stay low.
        i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        model_clear();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake.
    initial begin
        gexp_t g;
        dexp_t d;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk(!m_req && !i_addr_ok && !d_addr_ok && !i_data_ok && !d_data_ok, "reset_outputs",
                    64'({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 64'd0);
            end else begin
                chk(m_req == (gq.size() != 0), "m_req", 64'(m_req), 64'(gq.size() != 0));
                if (m_req && gq.size() != 0) begin
                    g = gq[0];
                    chk(m_addr == g.addr && m_wr == g.wr && m_size == g.size && m_wdata == g.wdata,
                        "req_fields", {m_addr, m_wdata}, {g.addr, g.wdata});
                    if (m_addr_ok) begin
                        chk(i_addr_ok == !g.side && d_addr_ok == g.side, "addr_ok_route",
                            64'({i_addr_ok, d_addr_ok}), 64'({!g.side, g.side}));
                        void'(gq.pop_front());
                    end
                end else if (i_addr_ok || d_addr_ok) begin
                    chk(1'b0, "addr_ok_unexpected", 64'({i_addr_ok, d_addr_ok}), 64'd0);
                end
                if (i_data_ok || d_data_ok) begin
                    if (dq.size() == 0) begin
                        chk(1'b0, "data_ok_unexpected", 64'({i_data_ok, d_data_ok}), 64'd0);
                    end else begin
                        d = dq.pop_front();
                        chk(i_data_ok == !d.side && d_data_ok == d.side, "data_ok_route",
                            64'({i_data_ok, d_data_ok}), 64'({!d.side, d.side}));
                        chk(i_rdata == d.rdata && d_rdata == d.rdata, "rdata",
                            {i_rdata, d_rdata}, {d.rdata, d.rdata});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        fix_rd = 0; p_spur = 0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_counters("reset");

        // Single inst read returning DEADBEEF, one grant to inst.
        fix_rd = 1; p_ireq = 100; p_dreq = 0; p_aok = 100; p_same = 0; p_dok = 50;
        step();
        p_ireq = 0;
        drain("single_inst");
        chk(n_ig == 1 && n_dg == 0, "single_inst_model", 64'(n_ig), 64'd1);
        fix_rd = 0;

        // Both sides held, one-cycle memory: D,D,D,D,I pattern.
        p_ireq = 100; p_dreq = 100; p_aok = 100; p_same = 0; p_dok = 100;
        repeat (60) step();
        drain("starve");

        // Memory withholds addr_ok for long stretches.
        p_ireq = 40; p_dreq = 30; p_aok = 15; p_same = 20; p_dok = 40;
        repeat (300) step();
        drain("slow_addr");

        // addr_ok and data_ok together: single-cycle transactions.
        p_ireq = 80; p_dreq = 80; p_aok = 100; p_same = 100; p_dok = 100; p_spur = 30;
        repeat (100) step();
        drain("one_cycle");

        // Mixed random traffic with spurious data_ok while idle.
        for (int k = 0; k < 4; k++) begin
            p_ireq = int'($urandom_range(100)); p_dreq = int'($urandom_range(100));
            p_aok = 10 + int'($urandom_range(90)); p_same = int'($urandom_range(100));
            p_dok = 10 + int'($urandom_range(90)); p_spur = 20;
            repeat (400) step();
            drain("random");
        end

        // Reset while waiting for data; the abandoned data_ok is never forwarded.
        p_ireq = 100; p_dreq = 0; p_aok = 100; p_same = 0; p_dok = 0; p_spur = 0;
        n = 0;
        step();
        while (!pend_data && n < 50) begin step(); n++; end
        chk(pend_data, "reach_wait_data", 64'(pend_data), 64'd1);
        do_reset(2);
        check_counters("after_reset");
        p_ireq = 0; p_dreq = 0; p_spur = 100;
        step();
        #2;
        chk(!i_data_ok && !d_data_ok, "post_reset_data_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
        p_spur = 0;
        p_ireq = 50; p_dreq = 50; p_aok = 60; p_same = 30; p_dok = 60;
        repeat (100) step();
        drain("post_reset");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
